// File: rtl/mem_write_ctrl.sv
// Write-side controller for byte lookup memories: word, bit-RMW and fill
// requests over valid/ready, with a registered read-first read port.
module mem_write_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [1:0]                wr_mode,
  input  logic [ADDR_W-1:0]         wr_base,
  input  logic [ADDR_W-1:0]         wr_offset,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic [$clog2(DATA_W)-1:0] wr_bit_sel,
  input  logic [ADDR_W-1:0]         wr_len,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int SW = $clog2(DATA_W);
  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  localparam logic [1:0] M_WORD = 2'b00;
  localparam logic [1:0] M_BIT  = 2'b01;
  localparam logic [1:0] M_FILL = 2'b10;

  typedef enum logic [1:0] {IDLE, BIT_RMW, FILL} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] count;
  logic [DATA_W-1:0] lat_data;
  logic [SW-1:0]     lat_sel;
  logic [ADDR_W-1:0] ea;
  logic              accept;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;

  function automatic logic oor(input logic [ADDR_W-1:0] a);
    return {1'b0, a} >= LIMIT;
  endfunction

  assign ea       = wr_base + wr_offset;
  assign wr_ready = (state == IDLE);
  assign busy     = ~wr_ready;
  assign accept   = wr_valid && wr_ready;

  // ptr doubles as the latched target address in BIT_RMW
  always_comb begin
    we = 1'b0;
    wa = ea;
    wd = wr_data;
    unique case (state)
      IDLE: begin
        we = accept && !oor(ea) &&
             (wr_mode == M_WORD || wr_mode == M_FILL);
      end
      BIT_RMW: begin
        wa = ptr;
        wd = mem[ptr[IW-1:0]];
        wd[lat_sel] = lat_data[0];
        we = !oor(ptr);
      end
      FILL: begin
        wa = ptr;
        wd = lat_data;
        we = !oor(ptr);
      end
      default: ;
    endcase
    we = we && rst_n;
  end

  always_ff @(posedge clk) begin
    if (we) mem[wa[IW-1:0]] <= wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      count    <= '0;
      lat_data <= '0;
      lat_sel  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      rd_data  <= '0;
    end else begin
      done    <= 1'b0;
      rd_data <= oor(rd_addr) ? '0 : mem[rd_addr[IW-1:0]];
      unique case (state)
        IDLE: begin
          if (wr_valid) begin
            lat_data <= wr_data;
            lat_sel  <= wr_bit_sel;
            count    <= wr_len;
            ptr      <= ea;
            unique case (1'b1)
              wr_mode == M_WORD: begin
                done <= 1'b1;
                err  <= oor(ea);
              end
              wr_mode == M_BIT: begin
                state <= BIT_RMW;
                err   <= 1'b0;
              end
              wr_mode == M_FILL: begin
                ptr <= ea + ONE;
                err <= oor(ea);
                if (wr_len == '0) done  <= 1'b1;
                else              state <= FILL;
              end
              default: begin
                done <= 1'b1;
                err  <= 1'b1;
              end
            endcase
          end
        end
        BIT_RMW: begin
          state <= IDLE;
          done  <= 1'b1;
          if (oor(ptr)) err <= 1'b1;
        end
        FILL: begin
          ptr   <= ptr + ONE;
          count <= count - ONE;
          if (oor(ptr)) err <= 1'b1;
          if (count == ONE) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_write_ctrl.sv
// Scoreboard bench for mem_write_ctrl: a full-depth and a DEPTH=128
// instance share stimulus and are compared against a reference model.
module tb_mem_write_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid;
  logic [1:0] wr_mode;
  logic [7:0] wr_base, wr_offset, wr_data, wr_len, rd_addr;
  logic [2:0] wr_bit_sel;

  logic       ready_a, busy_a, done_a, err_a;
  logic       ready_b, busy_b, done_b, err_b;
  logic [7:0] rdd_a, rdd_b;

  always #5 clk = ~clk;

  mem_write_ctrl u_full (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(ready_a),
    .wr_mode(wr_mode), .wr_base(wr_base), .wr_offset(wr_offset),
    .wr_data(wr_data), .wr_bit_sel(wr_bit_sel), .wr_len(wr_len),
    .rd_addr(rd_addr), .rd_data(rdd_a), .busy(busy_a), .done(done_a),
    .err(err_a)
  );

  mem_write_ctrl #(.DEPTH(128)) u_half (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(ready_b),
    .wr_mode(wr_mode), .wr_base(wr_base), .wr_offset(wr_offset),
    .wr_data(wr_data), .wr_bit_sel(wr_bit_sel), .wr_len(wr_len),
    .rd_addr(rd_addr), .rd_data(rdd_b), .busy(busy_b), .done(done_b),
    .err(err_b)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t        sb[$];
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] mdl [2][256];
  logic       merr [2];
  int         dep [2] = '{256, 128};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] got);
    sb_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check(e.tag, got, e.exp);
    end
  endtask

  task automatic model_req(input logic [1:0] mode, input logic [7:0] base,
                           input logic [7:0] off, input logic [7:0] data,
                           input logic [2:0] sel, input logic [7:0] len);
    logic [7:0] ea, a;
    ea = base + off;
    for (int k = 0; k < 2; k++) begin
      case (mode)
        2'd0: begin
          merr[k] = (int'(ea) >= dep[k]);
          if (!merr[k]) mdl[k][ea] = data;
        end
        2'd1: begin
          merr[k] = (int'(ea) >= dep[k]);
          if (!merr[k]) mdl[k][ea][sel] = data[0];
        end
        2'd2: begin
          merr[k] = 1'b0;
          for (int i = 0; i <= int'(len); i++) begin
            a = 8'(int'(ea) + i);
            if (int'(a) >= dep[k]) merr[k] = 1'b1;
            else mdl[k][a] = data;
          end
        end
        default: merr[k] = 1'b1;
      endcase
    end
  endtask

  task automatic req(input logic [1:0] mode, input logic [7:0] base,
                     input logic [7:0] off, input logic [7:0] data,
                     input logic [2:0] sel, input logic [7:0] len);
    int lat;
    int exp_lat;
    case (mode)
      2'd1:    exp_lat = 2;
      2'd2:    exp_lat = int'(len) + 1;
      default: exp_lat = 1;
    endcase
    check("ready_pre", {31'd0, ready_a}, 32'd1);
    wr_valid = 1'b1;
    wr_mode = mode;
    wr_base = base;
    wr_offset = off;
    wr_data = data;
    wr_bit_sel = sel;
    wr_len = len;
    push("done_lat", 32'(exp_lat));
    model_req(mode, base, off, data, sel, len);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    wr_mode = 2'($urandom);
    wr_base = 8'($urandom);
    wr_offset = 8'($urandom);
    wr_data = 8'($urandom);
    wr_bit_sel = 3'($urandom);
    wr_len = 8'($urandom);
    check("ready_acc", {31'd0, ready_a}, {31'd0, exp_lat == 1});
    lat = 1;
    while (!done_a && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
    end
    pop_check(32'(lat));
    check("done_b", {31'd0, done_b}, 32'd1);
    check("err_a", {31'd0, err_a}, {31'd0, merr[0]});
    check("err_b", {31'd0, err_b}, {31'd0, merr[1]});
    check("ready_done", {31'd0, ready_a}, 32'd1);
    check("busy_done", {31'd0, busy_a}, 32'd0);
  endtask

  task automatic rd(input logic [7:0] addr);
    rd_addr = addr;
    push("rd_a", {24'd0, mdl[0][addr]});
    push("rd_b", addr >= 8'h80 ? 32'd0 : {24'd0, mdl[1][addr]});
    @(posedge clk);
    #1;
    pop_check({24'd0, rdd_a});
    pop_check({24'd0, rdd_b});
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    wr_valid = 1'b0;
    wr_mode = 2'd0;
    wr_base = 8'd0;
    wr_offset = 8'd0;
    wr_data = 8'd0;
    wr_bit_sel = 3'd0;
    wr_len = 8'd0;
    rd_addr = 8'd0;
    merr[0] = 1'b0;
    merr[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ready_a}, 32'd1);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    check("rst_err", {31'd0, err_a}, 32'd0);
    check("rst_rd", {24'd0, rdd_a}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    req(2'd0, 8'h10, 8'h05, 8'hA5, 3'd0, 8'd0);
    rd(8'h15);
    req(2'd0, 8'hF0, 8'h20, 8'h3C, 3'd0, 8'd0);
    rd(8'h10);
    req(2'd1, 8'h10, 8'h05, 8'h01, 3'd1, 8'd0);
    rd(8'h15);
    req(2'd1, 8'h15, 8'h00, 8'hFE, 3'd7, 8'd0);
    rd(8'h15);

    req(2'd0, 8'h02, 8'h00, 8'hC3, 3'd0, 8'd0);
    req(2'd2, 8'hFE, 8'h00, 8'h5A, 3'd0, 8'd3);
    for (int i = 0; i < 5; i++) rd(8'(8'hFE + i));

    req(2'd0, 8'h80, 8'h10, 8'h99, 3'd0, 8'd0);
    rd(8'h90);
    req(2'd0, 8'h20, 8'h00, 8'h44, 3'd0, 8'd0);
    rd(8'h20);

    req(2'd3, 8'h30, 8'h00, 8'h12, 3'd0, 8'd0);
    req(2'd2, 8'h30, 8'h00, 8'h66, 3'd0, 8'd0);
    rd(8'h30);

    req(2'd2, 8'h40, 8'h00, 8'h11, 3'd0, 8'd15);
    wr_valid = 1'b1;
    wr_mode = 2'd2;
    wr_base = 8'h40;
    wr_offset = 8'h00;
    wr_data = 8'h77;
    wr_len = 8'd10;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) mdl[k][8'(8'h40 + i)] = 8'h77;
      merr[k] = 1'b0;
    end
    #1;
    check("mid_ready", {31'd0, ready_a}, 32'd1);
    check("mid_done", {31'd0, done_a}, 32'd0);
    check("mid_err", {31'd0, err_a}, 32'd0);
    check("mid_rd", {24'd0, rdd_a}, 32'd0);
    check("mid_ready_b", {31'd0, ready_b}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) rd(8'(8'h40 + i));

    req(2'd2, 8'h80, 8'h80, 8'hE1, 3'd0, 8'd255);
    rd(8'h00);
    rd(8'h7F);
    rd(8'h80);
    rd(8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
